// File: rtl/tm1638_pkg.sv
// Shared constants, state encoding and frame byte mapping for the TM1638 display writer.
package tm1638_pkg;

   localparam logic [7:0] TM_CMD_DATA_AUTO = 8'h40;
   localparam logic [7:0] TM_CMD_ADDR0     = 8'hC0;
   localparam logic [7:0] TM_CMD_DISP_ON   = 8'h88;

   // Frame selector: data command, display memory write, display control.
   localparam logic [1:0] FR_DATA = 2'd0;
   localparam logic [1:0] FR_DISP = 2'd1;
   localparam logic [1:0] FR_CTRL = 2'd2;

   typedef logic [2:0] tm_state_t;

   localparam tm_state_t ST_IDLE      = 3'd0;
   localparam tm_state_t ST_STB_LEAD  = 3'd1;
   localparam tm_state_t ST_BIT_LOW   = 3'd2;
   localparam tm_state_t ST_BIT_HIGH  = 3'd3;
   localparam tm_state_t ST_STB_TRAIL = 3'd4;
   localparam tm_state_t ST_STB_GAP   = 3'd5;
   localparam tm_state_t ST_DONE      = 3'd6;

   typedef struct packed {
      logic [63:0] digits;
      logic [7:0]  leds;
      logic [2:0]  brightness;
   } tm_snapshot_t;

   // Byte idx of a frame. In the display frame idx 0 is the address command,
   // then memory address (idx-1): even = digit segments, odd = LED bit.
   function automatic logic [7:0] tm_frame_byte(input logic [1:0] frame,
                                                input logic [4:0] idx,
                                                input tm_snapshot_t snap);
      logic [3:0] addr;
      logic [7:0] b;
      addr = 4'(idx - 5'd1);
      case (frame)
         FR_DISP: begin
            if (idx == 5'd0)
               b = TM_CMD_ADDR0;
            else if (!addr[0])
               b = snap.digits[{addr[3:1], 3'b000} +: 8];
            else
               b = {7'b0, snap.leds[addr[3:1]]};
         end
         FR_CTRL: b = TM_CMD_DISP_ON | {5'b0, snap.brightness};
         default: b = TM_CMD_DATA_AUTO;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/tm1638_display_writer_shifter.sv
// Serialises one byte LSB first as TM1638 CLK/DIO: low half with new data, then high half.
module tm1638_byte_shifter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] byte_in,
   input  logic       tick,
   output logic       tm_clk,
   output logic       tm_dio,
   output logic       byte_done
);

   logic [6:0] sh;
   logic [2:0] bit_idx;
   logic       active;

   // A load always starts a low half carrying bit 0; each tick toggles the clock phase
   // and a falling phase presents the next bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sh      <= '0;
         bit_idx <= '0;
         active  <= 1'b0;
         tm_clk  <= 1'b1;
         tm_dio  <= 1'b1;
      end else if (load) begin
         sh      <= byte_in[7:1];
         bit_idx <= '0;
         active  <= 1'b1;
         tm_clk  <= 1'b0;
         tm_dio  <= byte_in[0];
      end else if (active && tick) begin
         if (!tm_clk) begin
            tm_clk <= 1'b1;
         end else if (bit_idx == 3'd7) begin
            active <= 1'b0;
         end else begin
            bit_idx <= bit_idx + 3'd1;
            tm_clk  <= 1'b0;
            tm_dio  <= sh[0];
            sh      <= {1'b0, sh[6:1]};
         end
      end
   end

   assign byte_done = active && tick && tm_clk && (bit_idx == 3'd7);

endmodule

// File: rtl/tm1638_display_writer.sv
// TM1638 display refresh: snapshot inputs, then send data-command, display-memory and
// display-control frames over STB/CLK/DIO.
//
// state        | meaning
// IDLE         | pins idle high, waiting for start
// STB_LEAD     | STB low, CLK high, one half period before first bit
// BIT_LOW      | CLK low half, DIO carries current bit
// BIT_HIGH     | CLK high half, chip samples on the rising edge
// STB_TRAIL    | CLK high, STB still low, DIO held
// STB_GAP      | STB high, DIO released high
// DONE         | one-cycle completion pulse
module tm1638_display_writer
   import tm1638_pkg::*;
#(
   parameter int half_period = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] digits,
   input  logic [7:0]  leds,
   input  logic [2:0]  brightness,
   output logic        busy,
   output logic        done,
   output logic        tm_stb,
   output logic        tm_clk,
   output logic        tm_dio
);

   localparam int CW = (half_period > 1) ? $clog2(half_period) : 1;
   localparam logic [CW-1:0] HP_LAST = CW'(half_period - 1);

   tm_state_t    state;
   logic [CW-1:0] hp_cnt;
   logic [1:0]   frame;
   logic [4:0]   byte_idx;
   logic [4:0]   load_idx;
   tm_snapshot_t snap;
   logic         tick;
   logic         load;
   logic         byte_done;
   logic         last_byte;
   logic         dio_release;
   logic         sh_dio;
   logic [7:0]   load_byte;

   assign tick      = (hp_cnt == HP_LAST);
   assign last_byte = (frame == FR_DISP) ? (byte_idx == 5'd16) : 1'b1;
   assign load      = tick && ((state == ST_STB_LEAD) ||
                               ((state == ST_BIT_HIGH) && byte_done && !last_byte));
   assign load_idx  = (state == ST_STB_LEAD) ? 5'd0 : byte_idx + 5'd1;
   assign load_byte = tm_frame_byte(frame, load_idx, snap);

   // Half-period timer: restarts on acceptance so every phase is exactly H cycles.
   always_ff @(posedge clk) begin
      if (!reset)
         hp_cnt <= '0;
      else if ((state == ST_IDLE) || (state == ST_DONE) || tick)
         hp_cnt <= '0;
      else
         hp_cnt <= hp_cnt + CW'(1);
   end

   // Frame sequencer: STB framing, byte stepping and the start/done handshake.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         frame       <= FR_DATA;
         byte_idx    <= '0;
         snap        <= '0;
         dio_release <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  snap     <= {digits, leds, brightness};
                  frame    <= FR_DATA;
                  byte_idx <= '0;
                  state    <= ST_STB_LEAD;
               end
            end
            ST_STB_LEAD: begin
               if (tick) begin
                  dio_release <= 1'b0;
                  state       <= ST_BIT_LOW;
               end
            end
            ST_BIT_LOW: begin
               if (tick)
                  state <= ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
               if (tick) begin
                  if (byte_done && last_byte) begin
                     state <= ST_STB_TRAIL;
                  end else begin
                     if (byte_done)
                        byte_idx <= byte_idx + 5'd1;
                     state <= ST_BIT_LOW;
                  end
               end
            end
            ST_STB_TRAIL: begin
               if (tick) begin
                  dio_release <= 1'b1;
                  state       <= ST_STB_GAP;
               end
            end
            ST_STB_GAP: begin
               if (tick) begin
                  if (frame == FR_CTRL) begin
                     state <= ST_DONE;
                  end else begin
                     frame    <= frame + 2'd1;
                     byte_idx <= '0;
                     state    <= ST_STB_LEAD;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   tm1638_byte_shifter u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .byte_in   (load_byte),
      .tick      (tick),
      .tm_clk    (tm_clk),
      .tm_dio    (sh_dio),
      .byte_done (byte_done)
   );

   assign tm_dio = sh_dio | dio_release;
   assign busy   = (state != ST_IDLE) && (state != ST_DONE);
   assign done   = (state == ST_DONE);
   assign tm_stb = !((state == ST_STB_LEAD) || (state == ST_BIT_LOW) ||
                     (state == ST_BIT_HIGH) || (state == ST_STB_TRAIL));

endmodule

// File: tb/tb_tm1638_display_writer.sv
// Scoreboard bench: stimulus pushes expected bytes/refreshes, a TM1638 pin model pops and compares.
module tb_tm1638_display_writer;

   localparam int H = 2;
   localparam int REFRESH_CYC = 313 * H;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [63:0] digits = '0;
   logic [7:0]  leds = '0;
   logic [2:0]  brightness = '0;
   logic        busy, done, tm_stb, tm_clk, tm_dio;

   tm1638_display_writer #(.half_period(H)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .digits     (digits),
      .leds       (leds),
      .brightness (brightness),
      .busy       (busy),
      .done       (done),
      .tm_stb     (tm_stb),
      .tm_clk     (tm_clk),
      .tm_dio     (tm_dio)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_bytes[$];
   int         exp_done[$];

   // pin model state
   logic       prev_stb = 1'b1, prev_clk = 1'b1, prev_busy = 1'b0;
   logic [7:0] shreg = '0;
   int         bitcnt = 0, nb = 0, fr = 0, ndone = 0;
   int         acc_cyc = 0, rise_cyc = 0, last_done_cyc = 0;
   bit         rise_valid = 1'b0, b2b = 1'b0, b2b_seen_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon_step();
      logic [7:0] e;
      if (!reset) begin
         exp_bytes.delete();
         exp_done.delete();
         bitcnt     = 0;
         nb         = 0;
         fr         = 0;
         rise_valid = 1'b0;
      end else begin
         if (!tm_stb && tm_clk && !prev_clk) begin
            shreg = {tm_dio, shreg[7:1]};
            bitcnt++;
            if (bitcnt == 8) begin
               bitcnt = 0;
               if (exp_bytes.size() == 0) begin
                  check($sformatf("unexpected_byte_f%0d_b%0d", fr + 1, nb), 32'(shreg), 32'hFFFF_FFFF);
               end else begin
                  e = exp_bytes.pop_front();
                  check($sformatf("byte_f%0d_b%0d", fr + 1, nb), 32'(shreg), 32'(e));
               end
               nb++;
            end
         end
         if (tm_stb && !prev_stb) begin
            check($sformatf("frame_len_f%0d", fr + 1), 32'(nb), (fr == 1) ? 32'd17 : 32'd1);
            check($sformatf("frame_bits_f%0d", fr + 1), 32'(bitcnt), 32'd0);
            fr         = (fr + 1) % 3;
            nb         = 0;
            rise_cyc   = cyc;
            rise_valid = 1'b1;
         end
         if (!tm_stb && prev_stb && rise_valid) begin
            if (fr != 0)
               check("frame_gap", 32'(cyc - rise_cyc), 32'(H));
            else if (b2b && b2b_seen_done)
               check("refresh_gap", 32'(cyc - rise_cyc), 32'(H + 2));
         end
         if (busy && !prev_busy) begin
            if (b2b && b2b_seen_done)
               check("b2b_accept", 32'(cyc - last_done_cyc), 32'd2);
            acc_cyc = cyc;
         end
         if (done) begin
            ndone++;
            check("done_latency", 32'(cyc - acc_cyc), 32'(REFRESH_CYC));
            check("busy_at_done", 32'(busy), 32'd0);
            if (exp_done.size() == 0)
               check("unexpected_done", 32'd1, 32'd0);
            else
               void'(exp_done.pop_front());
            last_done_cyc = cyc;
            if (b2b)
               b2b_seen_done = 1'b1;
         end
      end
      if (!b2b)
         b2b_seen_done = 1'b0;
      prev_stb  = tm_stb;
      prev_clk  = tm_clk;
      prev_busy = busy;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      wait_cyc(1);
      start = 1'b0;
   endtask

   task automatic push_refresh(input logic [63:0] d, input logic [7:0] l, input logic [7:0] f3);
      exp_bytes.push_back(8'h40);
      exp_bytes.push_back(8'hC0);
      for (int i = 0; i < 8; i++) begin
         exp_bytes.push_back(d[8*i +: 8]);
         exp_bytes.push_back({7'b0, l[i]});
      end
      exp_bytes.push_back(f3);
      exp_done.push_back(1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (exp_done.size() != 0 && n < budget) begin
         wait_cyc(1);
         n++;
      end
      if (exp_done.size() != 0)
         check({name, "_timeout"}, 32'(exp_done.size()), 32'd0);
      wait_cyc(2);
      check({name, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
   endtask

   task automatic run_stim();
      logic [7:0] tbl[19];
      int         n0;
      int         n;
      tbl = '{8'h40, 8'hC0, 8'h07, 8'h01, 8'h7D, 8'h00, 8'h6D, 8'h01, 8'h66, 8'h00,
              8'h4F, 8'h00, 8'h5B, 8'h01, 8'h06, 8'h00, 8'h7F, 8'h01, 8'h8B};

      // reset values
      reset = 1'b0;
      wait_cyc(3);
      check("rst_stb", 32'(tm_stb), 32'd1);
      check("rst_clk", 32'(tm_clk), 32'd1);
      check("rst_dio", 32'(tm_dio), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wait_cyc(1);
         check("idle_pins", 32'({tm_stb, tm_clk, tm_dio, busy, done}), 32'b11100);
      end

      // full refresh against the hand table
      digits = 64'h7F06_5B4F_666D_7D07;
      leds = 8'hA5;
      brightness = 3'd3;
      for (int i = 0; i < 19; i++) exp_bytes.push_back(tbl[i]);
      exp_done.push_back(1);
      pulse_start();
      wait_idle("full", 2000);

      // snapshot and busy-ignore
      digits = 64'h3F06_5B4F_6677_7C39;
      leds = 8'h5A;
      brightness = 3'd6;
      push_refresh(64'h3F06_5B4F_6677_7C39, 8'h5A, 8'h8E);
      n0 = ndone;
      pulse_start();
      digits = '1;
      leds = '1;
      brightness = 3'd0;
      wait_cyc(48);
      pulse_start();
      wait_idle("snapshot", 2000);
      wait_cyc(20);
      check("snapshot_done_count", 32'(ndone - n0), 32'd1);

      // brightness extremes
      digits = 64'h7F06_5B4F_666D_7D07;
      leds = 8'hA5;
      brightness = 3'd0;
      push_refresh(64'h7F06_5B4F_666D_7D07, 8'hA5, 8'h88);
      pulse_start();
      wait_idle("bri0", 2000);
      brightness = 3'd7;
      push_refresh(64'h7F06_5B4F_666D_7D07, 8'hA5, 8'h8F);
      pulse_start();
      wait_idle("bri7", 2000);

      // reset during display frame byte 5
      brightness = 3'd3;
      push_refresh(64'h7F06_5B4F_666D_7D07, 8'hA5, 8'h8B);
      pulse_start();
      n = 0;
      while (!(fr == 1 && nb == 5) && n < 1000) begin
         wait_cyc(1);
         n++;
      end
      check("reach_f2_b5", 32'(fr == 1 && nb == 5), 32'd1);
      n0 = ndone;
      reset = 1'b0;
      wait_cyc(1);
      check("abort_pins", 32'({tm_stb, tm_clk, tm_dio, busy, done}), 32'b11100);
      wait_cyc(1);
      reset = 1'b1;
      wait_cyc(30);
      check("abort_no_done", 32'(ndone - n0), 32'd0);
      digits = 64'h0102_0304_0506_0708;
      leds = 8'h3C;
      brightness = 3'd5;
      push_refresh(64'h0102_0304_0506_0708, 8'h3C, 8'h8D);
      pulse_start();
      wait_idle("after_abort", 2000);

      // back-to-back with start held
      b2b = 1'b1;
      push_refresh(64'h0102_0304_0506_0708, 8'h3C, 8'h8D);
      push_refresh(64'h0102_0304_0506_0708, 8'h3C, 8'h8D);
      start = 1'b1;
      n = 0;
      while (exp_done.size() > 1 && n < 2000) begin
         wait_cyc(1);
         n++;
      end
      check("b2b_first_done", 32'(exp_done.size()), 32'd1);
      n = 0;
      while (!busy && n < 10) begin
         wait_cyc(1);
         n++;
      end
      check("b2b_reaccept", 32'(busy), 32'd1);
      start = 1'b0;
      wait_idle("b2b", 2000);
      b2b = 1'b0;
      wait_cyc(5);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
         run_stim();
      join_any
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
